// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared defaults, FSM encoding and entry packing for the register file
package reg_file_pkg;

  localparam int DEF_NUM_REGS = 2;
  localparam int DEF_WIDTH    = 16;
  localparam int DEF_ADDR_W   = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // Entry 0 lives in the most-significant slice of the packed bus.
  function automatic int entry_lsb(input int i, input int num_regs, input int width);
    return width * (num_regs - 1 - i);
  endfunction

endpackage

// File: rtl/reg_file_byte_merge.sv
// rtl/reg_file_byte_merge.sv - combinational byte-enable merge of new data into one entry
module reg_file_byte_merge
  import reg_file_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0]   old_i,
  input  logic [WIDTH-1:0]   new_i,
  input  logic [WIDTH/8-1:0] be_i,
  output logic [WIDTH-1:0]   merged_o
);

  always_comb begin
    merged_o = old_i;
    for (int k = 0; k < WIDTH / 8; k++) begin
      if (be_i[k]) begin
        merged_o[8*k +: 8] = new_i[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/reg_file_wr_ctrl.sv
// rtl/reg_file_wr_ctrl.sv - write-side controller: shadow entries, clear sequence, dirty and error flags
module reg_file_wr_ctrl
  import reg_file_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic [WIDTH/8-1:0]        wr_be,
  input  logic                      clr_req,
  output logic                      busy,
  input  logic                      dirty_clr,
  output logic [NUM_REGS*WIDTH-1:0] r_out,
  output logic [NUM_REGS-1:0]       dirty,
  output logic                      err
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                live_q;
  logic [WIDTH-1:0]    ent_q [NUM_REGS];
  logic [WIDTH-1:0]    ent_d [NUM_REGS];
  logic [WIDTH-1:0]    merged [NUM_REGS];
  logic [NUM_REGS-1:0] dirty_q, dirty_d;
  logic                err_q, err_d;
  logic                wr_fire;
  logic                addr_ok;

  assign addr_ok = {{(33 - ADDR_W){1'b0}}, wr_addr} < 33'(NUM_REGS);
  assign wr_fire = wr_valid && wr_ready;

  // live_q holds ready low until the first edge after reset release.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wr_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wr_ready = live_q;
        idx_d    = '0;
        if (clr_req) begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        busy  = 1'b1;
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(NUM_REGS - 1)) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_entry
    reg_file_byte_merge #(
      .WIDTH(WIDTH)
    ) u_merge (
      .old_i   (ent_q[g]),
      .new_i   (wr_data),
      .be_i    (wr_be),
      .merged_o(merged[g])
    );

    assign r_out[entry_lsb(g, NUM_REGS, WIDTH) +: WIDTH] = ent_q[g];
  end

  // A write always sets its dirty flag, so it overrides a coincident dirty_clr.
  always_comb begin
    ent_d   = ent_q;
    dirty_d = dirty_clr ? '0 : dirty_q;
    err_d   = err_q | (wr_fire && !addr_ok);
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_fire && addr_ok && (wr_addr == ADDR_W'(i))) begin
        ent_d[i]   = merged[i];
        dirty_d[i] = 1'b1;
      end
      if ((state_q == ST_CLEAR) && (idx_q == IDX_W'(i))) begin
        ent_d[i]   = '0;
        dirty_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      live_q  <= 1'b0;
      dirty_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      live_q  <= 1'b1;
      dirty_q <= dirty_d;
      err_q   <= err_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

  assign dirty = dirty_q;
  assign err   = err_q;

endmodule

// File: tb/tb_reg_file_wr_ctrl.sv
// tb/tb_reg_file_wr_ctrl.sv - directed scoreboard bench for reg_file_wr_ctrl (2-entry and 3-entry builds)
module tb_reg_file_wr_ctrl;

  logic        clock;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [0:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic        clr_req;
  logic        busy;
  logic        dirty_clr;
  logic [31:0] r_out;
  logic [1:0]  dirty;
  logic        err;

  logic        wr3_valid;
  logic        wr3_ready;
  logic [1:0]  wr3_addr;
  logic [15:0] wr3_data;
  logic [1:0]  wr3_be;
  logic        clr3_req;
  logic        busy3;
  logic        dirty3_clr;
  logic [47:0] r_out3;
  logic [2:0]  dirty3;
  logic        err3;

  int vectors;
  int miscompares;

  typedef struct {
    string       tag;
    logic [31:0] rout;
    logic [1:0]  dty;
  } exp_t;

  exp_t        sq[$];
  logic [15:0] m_ent [2];
  logic [1:0]  m_dirty;

  reg_file_wr_ctrl dut (
    .clock    (clock),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_be    (wr_be),
    .clr_req  (clr_req),
    .busy     (busy),
    .dirty_clr(dirty_clr),
    .r_out    (r_out),
    .dirty    (dirty),
    .err      (err)
  );

  reg_file_wr_ctrl #(
    .NUM_REGS(3),
    .WIDTH   (16),
    .ADDR_W  (2)
  ) dut3 (
    .clock    (clock),
    .reset    (reset),
    .wr_valid (wr3_valid),
    .wr_ready (wr3_ready),
    .wr_addr  (wr3_addr),
    .wr_data  (wr3_data),
    .wr_be    (wr3_be),
    .clr_req  (clr3_req),
    .busy     (busy3),
    .dirty_clr(dirty3_clr),
    .r_out    (r_out3),
    .dirty    (dirty3),
    .err      (err3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic logic [31:0] m_rout();
    return {m_ent[0], m_ent[1]};
  endfunction

  task automatic model_reset();
    m_ent[0] = '0;
    m_ent[1] = '0;
    m_dirty  = '0;
  endtask

  task automatic model_write(input logic [0:0] a, input logic [15:0] d, input logic [1:0] be);
    for (int k = 0; k < 2; k++) begin
      if (be[k]) m_ent[a][8*k +: 8] = d[8*k +: 8];
    end
    m_dirty[a] = 1'b1;
  endtask

  task automatic drive_wr(input logic [0:0] a, input logic [15:0] d, input logic [1:0] be);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    wr_be    = be;
    chk("wr_ready_at_write", 64'(wr_ready), 64'd1);
    model_write(a, d, be);
  endtask

  task automatic push(input string tag);
    exp_t e;
    e.tag  = tag;
    e.rout = m_rout();
    e.dty  = m_dirty;
    sq.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    chk("sb_underflow", 64'(sq.size() == 0), 64'd0);
    if (sq.size() != 0) begin
      e = sq.pop_front();
      chk({e.tag, "_rout"}, 64'(r_out), 64'(e.rout));
      chk({e.tag, "_dirty"}, 64'(dirty), 64'(e.dty));
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    wr_valid    = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    wr_be       = '0;
    clr_req     = 1'b0;
    dirty_clr   = 1'b0;
    wr3_valid   = 1'b0;
    wr3_addr    = '0;
    wr3_data    = '0;
    wr3_be      = '0;
    clr3_req    = 1'b0;
    dirty3_clr  = 1'b0;
    model_reset();

    repeat (2) @(negedge clock);
    chk("rst_rout", 64'(r_out), 64'd0);
    chk("rst_dirty", 64'(dirty), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(wr_ready), 64'd0);
    chk("rst_ready3", 64'(wr3_ready), 64'd0);
    reset = 1'b1;
    step();
    chk("post_rst_ready", 64'(wr_ready), 64'd1);
    chk("post_rst_ready3", 64'(wr3_ready), 64'd1);

    // Full write to entry 0.
    drive_wr(1'b0, 16'hABCD, 2'b11);
    push("w0_abcd");
    step();
    wr_valid = 1'b0;
    pop_check();
    chk("tp1_rout", 64'(r_out), 64'hABCD_0000);
    chk("tp1_dirty", 64'(dirty), 64'h1);

    // Partial write keeps the unselected byte.
    drive_wr(1'b1, 16'h1234, 2'b11);
    push("w1_1234");
    step();
    drive_wr(1'b1, 16'hFF00, 2'b01);
    push("w1_be01");
    pop_check();
    step();
    wr_valid = 1'b0;
    pop_check();
    chk("tp2_entry1", 64'(r_out[15:0]), 64'h1200);

    // Clear sequence with a write held across it.
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    chk("clr_c1_busy", 64'(busy), 64'd1);
    chk("clr_c1_ready", 64'(wr_ready), 64'd0);
    chk("clr_c1_rout", 64'(r_out), 64'hABCD_1200);
    wr_valid = 1'b1;
    wr_addr  = 1'b0;
    wr_data  = 16'h1111;
    wr_be    = 2'b11;
    step();
    chk("clr_c2_busy", 64'(busy), 64'd1);
    chk("clr_c2_ready", 64'(wr_ready), 64'd0);
    chk("clr_c2_rout", 64'(r_out), 64'h0000_1200);
    chk("clr_c2_dirty", 64'(dirty), 64'h2);
    step();
    chk("clr_c3_busy", 64'(busy), 64'd0);
    chk("clr_c3_ready", 64'(wr_ready), 64'd1);
    chk("clr_c3_rout", 64'(r_out), 64'd0);
    chk("clr_c3_dirty", 64'(dirty), 64'd0);
    model_reset();
    model_write(1'b0, 16'h1111, 2'b11);
    push("held_wr");
    step();
    wr_valid = 1'b0;
    pop_check();

    // Write and clear in the same cycle: write lands, then is cleared.
    drive_wr(1'b1, 16'h5555, 2'b11);
    clr_req = 1'b1;
    push("wr_clr_same");
    step();
    wr_valid = 1'b0;
    clr_req  = 1'b0;
    pop_check();
    chk("wrclr_busy", 64'(busy), 64'd1);
    step();
    chk("wrclr_mid_rout", 64'(r_out), 64'h0000_5555);
    chk("wrclr_mid_dirty", 64'(dirty), 64'h2);
    step();
    model_reset();
    push("wrclr_done");
    pop_check();
    chk("wrclr_busy_end", 64'(busy), 64'd0);

    // dirty_clr coinciding with a write: set wins for the written entry.
    drive_wr(1'b0, 16'hAAAA, 2'b11);
    step();
    drive_wr(1'b1, 16'hBBBB, 2'b11);
    step();
    wr_valid = 1'b0;
    chk("dclr_pre_dirty", 64'(dirty), 64'h3);
    dirty_clr = 1'b1;
    m_dirty   = '0;
    drive_wr(1'b0, 16'hCCCC, 2'b11);
    push("dclr_wr");
    step();
    wr_valid  = 1'b0;
    dirty_clr = 1'b0;
    pop_check();
    chk("dclr_dirty", 64'(dirty), 64'h1);

    // Three-entry build: in-range write, then an out-of-range one.
    wr3_valid = 1'b1;
    wr3_addr  = 2'd2;
    wr3_data  = 16'h0102;
    wr3_be    = 2'b11;
    step();
    wr3_valid = 1'b0;
    chk("n3_w2_rout", 64'(r_out3), 64'h0000_0000_0102);
    chk("n3_w2_dirty", 64'(dirty3), 64'h4);
    wr3_valid = 1'b1;
    wr3_addr  = 2'd3;
    wr3_data  = 16'hFFFF;
    chk("n3_oob_ready", 64'(wr3_ready), 64'd1);
    step();
    wr3_valid = 1'b0;
    chk("n3_oob_rout", 64'(r_out3), 64'h0000_0000_0102);
    chk("n3_oob_dirty", 64'(dirty3), 64'h4);
    chk("n3_oob_err", 64'(err3), 64'd1);
    chk("n2_err_clean", 64'(err), 64'd0);
    repeat (3) step();
    chk("n3_err_sticky", 64'(err3), 64'd1);

    // Reset in the cycle after clr_req.
    drive_wr(1'b1, 16'h7777, 2'b11);
    push("w1_7777");
    step();
    wr_valid = 1'b0;
    pop_check();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    chk("mid_clr_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    chk("arst_rout", 64'(r_out), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_ready", 64'(wr_ready), 64'd0);
    chk("arst_dirty", 64'(dirty), 64'd0);
    chk("arst_err3", 64'(err3), 64'd0);
    chk("arst_rout3", 64'(r_out3), 64'd0);
    model_reset();
    step();
    reset = 1'b1;
    step();
    chk("rel_ready", 64'(wr_ready), 64'd1);
    chk("rel_busy", 64'(busy), 64'd0);

    drive_wr(1'b0, 16'h0F0F, 2'b10);
    push("post_rst_wr");
    step();
    wr_valid = 1'b0;
    pop_check();
    chk("post_rst_rout", 64'(r_out), 64'h0F00_0000);
    chk("sb_empty", 64'(sq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
